issue_dispatch_ctrl: RTL and testbench
======================================

Name: issue_dispatch_ctrl

Overview:
- Controller for the 4-in/1-out issue queue.
- Tracks which issue slots are occupied and allocates free slots to up to 4 dispatched uops per cycle (lowest-free-first, lane-order compacted).
- Selects one ready slot per cycle for issue.
- Frees slots on issue grant or branch kill.
- Produces the per-slot write enables and lane selects that steer the queue datapath.

Parameters:
- SLOTS, 8, number of issue slots (power of 2, ≥4).
- WIDTH_BRM, 3, branch-mask width per uop.
- WIDTH_IDX, 3, slot index width (log2 SLOTS).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid4x  in  4  dispatch lane valids, lane 0 oldest.
- i_brm4x  in  4*WIDTH_BRM  branch masks of lanes; lane k in bits [k*WIDTH_BRM +: WIDTH_BRM].
- o_ready  out  1  dispatch group accepted this cycle.
- o_slot_we  out  SLOTS  slot s latches a new uop at the next edge.
- o_slot_lane  out  2*SLOTS  lane feeding slot s, in bits [2s+1:2s].
- i_req  in  SLOTS  slot s operands ready (from issue slots).
- i_stall  in  1  execution unit busy; no grant this cycle.
- i_BrKill  in  WIDTH_BRM  branch kill mask.
- o_grant  out  SLOTS  one-hot issue grant, or zero.
- o_grant_idx  out  WIDTH_IDX  index of the granted slot; 0 when no grant.
- o_issue_valid  out  1  |o_grant.
- o_count  out  WIDTH_IDX+1  occupied-slot count.

Behaviour:
- State: occupied bitmap occ[SLOTS], per-slot mask brm[s], and rr pointer (only with the optional feature).
- Reset: all state cleared.
  - occ=0, o_count=0, o_grant=0, o_issue_valid=0, o_slot_we=0.
  - o_ready=0 while i_rst_n=0.
  - Reset asserted mid-operation discards all in-flight state immediately.
- Outputs are combinational from state and inputs; state updates on the rising edge.
- Kill match for slot s: occ[s] & |(brm[s] & i_BrKill).
- Kill match for lane k: |(i_brm4x[k] & i_BrKill).
- Dispatch:
  - need = number of valid lanes with no kill match.
  - free = SLOTS - o_count. Slots freed this cycle are NOT counted.
  - o_ready = (free ≥ need).
  - Acceptance is all-or-nothing. If ~o_ready, no allocation happens and the upstream holds the group.
  - On acceptance, the j-th surviving lane (in lane order) takes the j-th lowest-index free slot:
    - o_slot_we[s]=1;
    - o_slot_lane[s] = lane number;
    - at the edge, occ[s] is set and brm[s] is loaded from that lane.
  - Killed lanes are consumed but allocate nothing.
  - i_valid4x=0 gives o_ready=1 and no writes.
- Issue select:
  - cand = i_req & occ & ~killmatch & {SLOTS{~i_stall}}.
  - Grant the lowest-index cand bit. Kill always beats grant.
  - At the edge the granted slot clears occ.
- Kill: every slot with a kill match clears occ at the edge.
- Simultaneous events:
  - Grant and kill on different slots both free their slot.
  - A slot freed this cycle is not allocatable until the next cycle, so it never sees we together with grant or kill.
- o_count updates each edge to allocated minus granted minus killed. It never exceeds SLOTS and never goes below 0; the verification engineer asserts both.
- Slots with occ=0 have don't-care brm; brm must be ignored for them.

Optional Feature:
- Macro ISSUE_RR_EN.
- Defined:
  - Issue select uses rotating priority starting at rr pointer: search order rr, rr+1, … wrapping modulo SLOTS.
  - rr advances to grant_idx+1 (wrapping) on each grant and holds otherwise. Reset value is 0.
- Undefined:
  - Fixed priority, lowest index first.
  - No rr register exists.

Decomposition:
- Shared package or header holds:
  - the lane-field offsets for i_brm4x;
  - the o_slot_lane encoding (2 bits per slot);
  - a popcount function;
  - a find-first-set function (lowest set bit index, with a found flag).
- Natural sub-module: issue_select, a SLOTS-wide priority picker.
  - Inputs: cand vector, plus rr under ISSUE_RR_EN.
  - Outputs: one-hot grant, index, valid.
- Allocation stays inline in issue_dispatch_ctrl.

Test Plan:
- Reset then all 4 lanes valid, brm=0, i_BrKill=0 → o_ready=1, o_slot_we=8'h0F, lanes 0..3 map to slots 0..3; next cycle o_count=4.
- occ=8'hFC (count 6), lanes 0,2,3 valid → o_ready=0, o_slot_we=0; after one grant of slot 3 → o_ready=1 next cycle, lanes take slots 0,1,3.
- occ=8'hFF, i_req=8'h28, i_stall=0, fixed priority → o_grant=8'h08, o_grant_idx=3; occ=8'hF7 next cycle. With i_stall=1 → o_grant=0.
- brm of slots 1,4 = 3'b010, other occupied slots brm=3'b001, i_BrKill=3'b010, i_req on slot 1 → o_grant=0; slots 1 and 4 free next cycle; o_count drops by 2.
- Lanes 0..3 valid, lane 1 brm=3'b010, i_BrKill=3'b010, 3 free slots → o_ready=1, 3 slots written, lane 1 dropped.
- ISSUE_RR_EN defined, i_req=8'hFF held, occ refilled every cycle → grants rotate through slots 0,1,2,…,7,0. Assert i_rst_n=0 mid-stream → o_count=0 and o_grant=0 immediately.

Source files
------------

// File: rtl/issue_dispatch_ctrl_pkg.sv
// Shared definitions for issue_dispatch_ctrl: dispatch lane/slot field layout and bit-scan helpers.
package issue_dispatch_ctrl_pkg;

    localparam int LANES      = 4;
    localparam int LANE_SEL_W = 2;
    localparam int SCAN_W     = 64;

    typedef struct packed {
        logic       found;
        logic [5:0] idx;
    } ffs_t;

    function automatic int brm_lane_lo(input int lane, input int width_brm);
        return lane * width_brm;
    endfunction

    function automatic int slot_lane_lo(input int slot);
        return slot * LANE_SEL_W;
    endfunction

    function automatic logic [6:0] popcount(input logic [SCAN_W-1:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < SCAN_W; i++) begin
            n = n + 7'(v[i]);
        end
        return n;
    endfunction

    // Scans from the top down so the last hit written is the lowest set bit.
    function automatic ffs_t find_first_set(input logic [SCAN_W-1:0] v);
        ffs_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = SCAN_W - 1; i >= 0; i--) begin
            if (v[i]) begin
                r.found = 1'b1;
                r.idx   = 6'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/issue_dispatch_ctrl_select.sv
// SLOTS-wide issue priority picker: fixed lowest-index-first, or rotating from i_rr when ISSUE_RR_EN is defined.
import issue_dispatch_ctrl_pkg::*;

module issue_select #(
    parameter int SLOTS     = 8,
    parameter int WIDTH_IDX = 3
) (
    input  logic [SLOTS-1:0]     i_cand,
`ifdef ISSUE_RR_EN
    input  logic [WIDTH_IDX-1:0] i_rr,
`endif
    output logic [SLOTS-1:0]     o_grant,
    output logic [WIDTH_IDX-1:0] o_idx,
    output logic                 o_valid
);

    ffs_t pick;

`ifdef ISSUE_RR_EN
    logic [SLOTS-1:0] rotated;
    logic [SLOTS-1:0] hit;

    // Rotate so i_rr lands at bit 0, scan, then rotate the one-hot back.
    always_comb begin
        rotated = '0;
        for (int i = 0; i < SLOTS; i++) begin
            rotated[i] = i_cand[WIDTH_IDX'(i + int'(i_rr))];
        end
        pick    = find_first_set(SCAN_W'(rotated));
        hit     = SLOTS'(1) << pick.idx;
        o_grant = '0;
        for (int i = 0; i < SLOTS; i++) begin
            o_grant[WIDTH_IDX'(i + int'(i_rr))] = hit[i] & pick.found;
        end
        o_valid = pick.found;
        o_idx   = pick.found ? i_rr + WIDTH_IDX'(pick.idx) : '0;
    end
`else
    always_comb begin
        pick    = find_first_set(SCAN_W'(i_cand));
        o_valid = pick.found;
        o_grant = pick.found ? (SLOTS'(1) << pick.idx) : '0;
        o_idx   = pick.found ? WIDTH_IDX'(pick.idx) : '0;
    end
`endif

endmodule

// File: rtl/issue_dispatch_ctrl.sv
// Issue queue controller: slot occupancy, 4-wide compacted dispatch allocation, issue select and branch kill.
// Define ISSUE_RR_EN for rotating issue priority; otherwise lowest index wins.
import issue_dispatch_ctrl_pkg::*;

module issue_dispatch_ctrl #(
    parameter int SLOTS     = 8,
    parameter int WIDTH_BRM = 3,
    parameter int WIDTH_IDX = 3
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [LANES-1:0]           i_valid4x,
    input  logic [LANES*WIDTH_BRM-1:0] i_brm4x,
    output logic                       o_ready,
    output logic [SLOTS-1:0]           o_slot_we,
    output logic [2*SLOTS-1:0]         o_slot_lane,
    input  logic [SLOTS-1:0]           i_req,
    input  logic                       i_stall,
    input  logic [WIDTH_BRM-1:0]       i_BrKill,
    output logic [SLOTS-1:0]           o_grant,
    output logic [WIDTH_IDX-1:0]       o_grant_idx,
    output logic                       o_issue_valid,
    output logic [WIDTH_IDX:0]         o_count
);

    logic [SLOTS-1:0]                 occ_q;
    logic [SLOTS-1:0][WIDTH_BRM-1:0]  brm_q;
    logic [WIDTH_IDX:0]               count_q;
    logic [SLOTS-1:0]                 slot_kill;
    logic [SLOTS-1:0]                 cand;
    logic [SLOTS-1:0]                 occ_next;
    logic [LANES-1:0]                 lane_ok;
    logic [LANE_SEL_W-1:0]            lane_list [LANES];
    logic [2:0]                       n_ok;
    logic [2:0]                       n_alloc;
    logic [WIDTH_IDX:0]               need;
    logic [WIDTH_IDX:0]               free_slots;

`ifdef ISSUE_RR_EN
    logic [WIDTH_IDX-1:0]             rr_q;
`endif

    // Freed slots stay occupied in occ_q until the edge, so they are never offered for allocation this cycle.
    always_comb begin
        slot_kill = '0;
        for (int s = 0; s < SLOTS; s++) begin
            slot_kill[s] = occ_q[s] & (|(brm_q[s] & i_BrKill));
        end

        lane_ok   = '0;
        lane_list = '{default: '0};
        n_ok      = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_ok[k] = i_valid4x[k] & ~(|(i_brm4x[brm_lane_lo(k, WIDTH_BRM) +: WIDTH_BRM] & i_BrKill));
            if (lane_ok[k]) begin
                lane_list[n_ok[1:0]] = LANE_SEL_W'(k);
                n_ok = n_ok + 3'd1;
            end
        end

        need       = (WIDTH_IDX+1)'(popcount(SCAN_W'(lane_ok)));
        free_slots = (WIDTH_IDX+1)'(SLOTS) - count_q;
        o_ready    = i_rst_n && (free_slots >= need);

        o_slot_we   = '0;
        o_slot_lane = '0;
        n_alloc     = '0;
        for (int s = 0; s < SLOTS; s++) begin
            if (o_ready && !occ_q[s] && (n_alloc < n_ok)) begin
                o_slot_we[s] = 1'b1;
                o_slot_lane[slot_lane_lo(s) +: LANE_SEL_W] = lane_list[n_alloc[1:0]];
                n_alloc = n_alloc + 3'd1;
            end
        end

        cand     = i_req & occ_q & ~slot_kill & {SLOTS{~i_stall}};
        occ_next = (occ_q & ~o_grant & ~slot_kill) | o_slot_we;
    end

    issue_select #(
        .SLOTS     (SLOTS),
        .WIDTH_IDX (WIDTH_IDX)
    ) u_issue_select (
        .i_cand  (cand),
`ifdef ISSUE_RR_EN
        .i_rr    (rr_q),
`endif
        .o_grant (o_grant),
        .o_idx   (o_grant_idx),
        .o_valid (o_issue_valid)
    );

    assign o_count = count_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            occ_q   <= '0;
            brm_q   <= '0;
            count_q <= '0;
`ifdef ISSUE_RR_EN
            rr_q    <= '0;
`endif
        end else begin
            occ_q   <= occ_next;
            count_q <= (WIDTH_IDX+1)'(popcount(SCAN_W'(occ_next)));
            for (int s = 0; s < SLOTS; s++) begin
                if (o_slot_we[s]) begin
                    brm_q[s] <= i_brm4x[brm_lane_lo(int'(o_slot_lane[slot_lane_lo(s) +: LANE_SEL_W]), WIDTH_BRM) +: WIDTH_BRM];
                end
            end
`ifdef ISSUE_RR_EN
            if (o_issue_valid) begin
                rr_q <= o_grant_idx + WIDTH_IDX'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_issue_dispatch_ctrl.sv
// Scoreboard bench for issue_dispatch_ctrl: directed scenarios plus random traffic against a slot-list reference model.
module tb_issue_dispatch_ctrl;

    localparam int SLOTS = 8;
    localparam int WB    = 3;
    localparam int WI    = 3;

    logic               i_clk = 1'b0;
    logic               i_rst_n = 1'b0;
    logic [3:0]         i_valid4x = '0;
    logic [4*WB-1:0]    i_brm4x = '0;
    logic               o_ready;
    logic [SLOTS-1:0]   o_slot_we;
    logic [2*SLOTS-1:0] o_slot_lane;
    logic [SLOTS-1:0]   i_req = '0;
    logic               i_stall = 1'b0;
    logic [WB-1:0]      i_BrKill = '0;
    logic [SLOTS-1:0]   o_grant;
    logic [WI-1:0]      o_grant_idx;
    logic               o_issue_valid;
    logic [WI:0]        o_count;

    issue_dispatch_ctrl #(.SLOTS(SLOTS), .WIDTH_BRM(WB), .WIDTH_IDX(WI)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_valid4x     (i_valid4x),
        .i_brm4x       (i_brm4x),
        .o_ready       (o_ready),
        .o_slot_we     (o_slot_we),
        .o_slot_lane   (o_slot_lane),
        .i_req         (i_req),
        .i_stall       (i_stall),
        .i_BrKill      (i_BrKill),
        .o_grant       (o_grant),
        .o_grant_idx   (o_grant_idx),
        .o_issue_valid (o_issue_valid),
        .o_count       (o_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic               ready;
        logic [SLOTS-1:0]   we;
        logic [2*SLOTS-1:0] lane;
        logic [SLOTS-1:0]   grant;
        logic [WI-1:0]      idx;
        logic               iv;
        logic [WI:0]        count;
    } exp_t;

    exp_t     expq[$];
    int       n_checks = 0;
    int       n_fail   = 0;
    bit       monitor_on = 1'b0;

    bit       occ_m  [SLOTS];
    bit [2:0] brm_m  [SLOTS];
    int       rr_m;
    bit       occ_n  [SLOTS];
    bit [2:0] brm_n  [SLOTS];
    int       rr_n;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int s = 0; s < SLOTS; s++) begin
            occ_m[s] = 1'b0;
            brm_m[s] = '0;
        end
        rr_m = 0;
    endtask

    // Expected outputs for the current inputs, plus the state after the coming edge.
    task automatic modelStep(output exp_t e);
        int survivors[$];
        int freelist[$];
        bit killed[SLOTS];
        int cnt;
        int start;
        int g;
        cnt = 0;
        for (int s = 0; s < SLOTS; s++) begin
            cnt += occ_m[s];
            occ_n[s] = occ_m[s];
            brm_n[s] = brm_m[s];
            killed[s] = occ_m[s] && ((brm_m[s] & i_BrKill) != 0);
            if (!occ_m[s]) freelist.push_back(s);
        end
        for (int k = 0; k < 4; k++) begin
            if (i_valid4x[k] && ((i_brm4x[k*WB +: WB] & i_BrKill) == 0)) survivors.push_back(k);
        end
        e.count = (WI+1)'(cnt);
        e.ready = (SLOTS - cnt) >= survivors.size();
        e.we    = '0;
        e.lane  = '0;
        e.grant = '0;
        e.idx   = '0;
        e.iv    = 1'b0;
        g = -1;
`ifdef ISSUE_RR_EN
        start = rr_m;
`else
        start = 0;
`endif
        if (!i_stall) begin
            for (int step = 0; step < SLOTS; step++) begin
                int s;
                s = (start + step) % SLOTS;
                if (g < 0 && occ_m[s] && i_req[s] && !killed[s]) g = s;
            end
        end
        rr_n = rr_m;
        if (g >= 0) begin
            e.grant[g] = 1'b1;
            e.idx      = WI'(g);
            e.iv       = 1'b1;
            rr_n       = (g + 1) % SLOTS;
        end
        for (int s = 0; s < SLOTS; s++) begin
            if (killed[s] || s == g) occ_n[s] = 1'b0;
        end
        if (e.ready) begin
            for (int j = 0; j < survivors.size(); j++) begin
                int s;
                s = freelist[j];
                e.we[s] = 1'b1;
                e.lane[2*s +: 2] = 2'(survivors[j]);
                occ_n[s] = 1'b1;
                brm_n[s] = i_brm4x[survivors[j]*WB +: WB];
            end
        end
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic [4*WB-1:0] b, input logic [SLOTS-1:0] r,
                                 input logic st, input logic [WB-1:0] k);
        exp_t e;
        i_valid4x = v;
        i_brm4x   = b;
        i_req     = r;
        i_stall   = st;
        i_BrKill  = k;
        modelStep(e);
        expq.push_back(e);
        @(posedge i_clk);
        for (int s = 0; s < SLOTS; s++) begin
            occ_m[s] = occ_n[s];
            brm_m[s] = brm_n[s];
        end
        rr_m = rr_n;
        #1;
    endtask

    task automatic doReset();
        monitor_on = 1'b0;
        i_rst_n    = 1'b0;
        i_valid4x  = '0;
        i_brm4x    = '0;
        i_req      = '0;
        i_stall    = 1'b0;
        i_BrKill   = '0;
        expq.delete();
        modelReset();
        @(posedge i_clk);
        #1;
        checkOutput("reset-count", 32'(o_count), 0);
        checkOutput("reset-ready", 32'(o_ready), 0);
        checkOutput("reset-we", 32'(o_slot_we), 0);
        checkOutput("reset-grant", 32'(o_grant), 0);
        checkOutput("reset-issue-valid", 32'(o_issue_valid), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        monitor_on = 1'b1;
    endtask

    // Monitor: every cycle the DUT presents outputs, pop the scoreboard entry and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (monitor_on) begin
                if (expq.size() == 0) begin
                    checkOutput("scoreboard-empty", 1, 0);
                end else begin
                    e = expq.pop_front();
                    checkOutput("ready", 32'(o_ready), 32'(e.ready));
                    checkOutput("slot-we", 32'(o_slot_we), 32'(e.we));
                    checkOutput("slot-lane", 32'(o_slot_lane), 32'(e.lane));
                    checkOutput("grant", 32'(o_grant), 32'(e.grant));
                    checkOutput("grant-idx", 32'(o_grant_idx), 32'(e.idx));
                    checkOutput("issue-valid", 32'(o_issue_valid), 32'(e.iv));
                    checkOutput("count", 32'(o_count), 32'(e.count));
                    checkOutput("count-bound", 32'(o_count <= SLOTS), 1);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting issue_dispatch_ctrl bench");
        doReset();

        // Fill, drain two low slots, then a blocked group that unblocks after one grant.
        applyStimulus(4'hF, '0, 8'h00, 1'b0, 3'b000);
        applyStimulus(4'hF, '0, 8'h00, 1'b0, 3'b000);
        applyStimulus(4'h0, '0, 8'h01, 1'b0, 3'b000);
        applyStimulus(4'h0, '0, 8'h02, 1'b0, 3'b000);
        applyStimulus(4'hD, '0, 8'h00, 1'b0, 3'b000);
        applyStimulus(4'hD, '0, 8'h08, 1'b0, 3'b000);
        applyStimulus(4'hD, '0, 8'h00, 1'b0, 3'b000);
        applyStimulus(4'h0, '0, 8'h28, 1'b0, 3'b000);
        applyStimulus(4'h0, '0, 8'h28, 1'b1, 3'b000);
        applyStimulus(4'h0, '0, 8'h00, 1'b0, 3'b000);

        // Branch kill of slots 1 and 4 beating a request on slot 1, then a killed dispatch lane.
        doReset();
        applyStimulus(4'hF, 12'h251, 8'h00, 1'b0, 3'b000);
        applyStimulus(4'hF, 12'h24A, 8'h00, 1'b0, 3'b000);
        applyStimulus(4'h0, '0, 8'h02, 1'b0, 3'b010);
        applyStimulus(4'h0, '0, 8'h00, 1'b0, 3'b000);
        applyStimulus(4'h0, '0, 8'h01, 1'b0, 3'b000);
        applyStimulus(4'hF, 12'h010, 8'h00, 1'b0, 3'b010);
        applyStimulus(4'h0, '0, 8'h00, 1'b0, 3'b000);

        // Continuous refill with every slot requesting.
        doReset();
        for (int c = 0; c < 20; c++) begin
            applyStimulus(4'hF, '0, 8'hFF, 1'b0, 3'b000);
        end

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            logic [WB-1:0] kill;
            kill = ($urandom_range(0, 7) == 0) ? WB'($urandom_range(1, 7)) : '0;
            applyStimulus(4'($urandom), 12'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0), kill);
        end

        // Reset mid-stream must drop everything immediately.
        monitor_on = 1'b0;
        i_req      = 8'hFF;
        i_valid4x  = 4'hF;
        i_stall    = 1'b0;
        i_BrKill   = '0;
        #2;
        i_rst_n = 1'b0;
        #1;
        checkOutput("midreset-count", 32'(o_count), 0);
        checkOutput("midreset-grant", 32'(o_grant), 0);
        checkOutput("midreset-issue-valid", 32'(o_issue_valid), 0);
        checkOutput("midreset-ready", 32'(o_ready), 0);
        doReset();
        applyStimulus(4'h3, '0, 8'h00, 1'b0, 3'b000);
        applyStimulus(4'h0, '0, 8'h00, 1'b0, 3'b000);
        monitor_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
